// File: rtl/commu_rx_main.sv
// commu_rx_main: receive frame sequencer that hunts the head, captures LEN and payload,
// verifies checksum and tail, then streams the payload out over valid/ready.
module commu_rx_main #(
    parameter int         MAX_LEN = 64,
    parameter int         TIMEOUT = 100000,
    parameter logic [7:0] HEAD0   = 8'hEB,
    parameter logic [7:0] HEAD1   = 8'h90,
    parameter logic [7:0] TAIL    = 8'h0D
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        rx_vld,
    input  logic [7:0]  rx_data,
    input  logic [7:0]  cfg_recvEn,
    output logic        out_vld,
    output logic [7:0]  out_data,
    output logic        out_last,
    input  logic        out_rdy,
    output logic        frm_ok,
    output logic        frm_err,
    output logic [2:0]  err_code,
    output logic        rx_busy,
    output logic [15:0] cnt_ok,
    output logic [15:0] cnt_err
);
    localparam int PW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    localparam int GW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_HEAD2, S_LEN, S_DATA, S_SUM, S_TAIL, S_OUT} state_t;

    state_t        state_q;
    logic [7:0]    sum_q;
    logic [PW-1:0] last_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [GW-1:0] gap_q;
    logic [7:0]    mem_q [MAX_LEN];
    logic          out_vld_q;
    logic [7:0]    out_data_q;
    logic          out_last_q;
    logic          frm_ok_q;
    logic          frm_err_q;
    logic [2:0]    err_code_q;
    logic [15:0]   cnt_ok_q;
    logic [15:0]   cnt_err_q;
    logic          active;
    logic          len_bad;
    logic          unused_cfg;

    assign active     = state_q != S_IDLE && state_q != S_OUT;
    assign len_bad    = rx_data == 8'd0 || 32'(rx_data) > MAX_LEN;
    assign unused_cfg = ^cfg_recvEn[7:1];

    always_ff @(posedge clk_sys)
        if (!rst && state_q == S_DATA && rx_vld && cfg_recvEn[0])
            mem_q[wr_ptr_q] <= rx_data;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sum_q      <= '0;
            last_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            gap_q      <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            frm_ok_q   <= 1'b0;
            frm_err_q  <= 1'b0;
            err_code_q <= '0;
            cnt_ok_q   <= '0;
            cnt_err_q  <= '0;
        end else begin
            frm_ok_q  <= 1'b0;
            frm_err_q <= 1'b0;
            if (frm_ok_q && ~&cnt_ok_q)
                cnt_ok_q <= cnt_ok_q + 16'd1;
            if (frm_err_q && ~&cnt_err_q)
                cnt_err_q <= cnt_err_q + 16'd1;
            gap_q <= (active && !rx_vld) ? gap_q + GW'(1) : '0;
            // Dropping the enable beats a pending timeout so a disabled receiver never reports errors
            if (active && !cfg_recvEn[0]) begin
                state_q <= S_IDLE;
            end else if (active && !rx_vld && gap_q == GW'(TIMEOUT - 1)) begin
                state_q    <= S_IDLE;
                frm_err_q  <= 1'b1;
                err_code_q <= 3'd4;
            end else begin
                case (state_q)
                    S_IDLE:
                        if (rx_vld && cfg_recvEn[0] && rx_data == HEAD0)
                            state_q <= S_HEAD2;
                    S_HEAD2:
                        if (rx_vld)
                            state_q <= rx_data == HEAD1 ? S_LEN : rx_data == HEAD0 ? S_HEAD2 : S_IDLE;
                    S_LEN:
                        if (rx_vld) begin
                            sum_q    <= rx_data;
                            last_q   <= PW'(rx_data - 8'd1);
                            wr_ptr_q <= '0;
                            state_q  <= len_bad ? S_IDLE : S_DATA;
                            if (len_bad) begin
                                frm_err_q  <= 1'b1;
                                err_code_q <= 3'd1;
                            end
                        end
                    S_DATA:
                        if (rx_vld) begin
                            sum_q    <= sum_q + rx_data;
                            wr_ptr_q <= wr_ptr_q + PW'(1);
                            if (wr_ptr_q == last_q)
                                state_q <= S_SUM;
                        end
                    S_SUM:
                        if (rx_vld) begin
                            state_q <= rx_data == sum_q ? S_TAIL : S_IDLE;
                            if (rx_data != sum_q) begin
                                frm_err_q  <= 1'b1;
                                err_code_q <= 3'd2;
                            end
                        end
                    S_TAIL:
                        if (rx_vld) begin
                            if (rx_data != TAIL) begin
                                state_q    <= S_IDLE;
                                frm_err_q  <= 1'b1;
                                err_code_q <= 3'd3;
                            end else begin
                                state_q    <= S_OUT;
                                rd_ptr_q   <= '0;
                                out_vld_q  <= 1'b1;
                                out_data_q <= mem_q[PW'(0)];
                                out_last_q <= last_q == '0;
                                frm_ok_q   <= 1'b1;
                            end
                        end
                    S_OUT: begin
                        if (rx_vld) begin
                            frm_err_q  <= 1'b1;
                            err_code_q <= 3'd5;
                        end
                        if (out_rdy && out_last_q) begin
                            state_q    <= S_IDLE;
                            out_vld_q  <= 1'b0;
                            out_last_q <= 1'b0;
                        end else if (out_rdy) begin
                            rd_ptr_q   <= rd_ptr_q + PW'(1);
                            out_data_q <= mem_q[rd_ptr_q + PW'(1)];
                            out_last_q <= rd_ptr_q + PW'(1) == last_q;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign out_last = out_last_q;
    assign frm_ok   = frm_ok_q;
    assign frm_err  = frm_err_q;
    assign err_code = err_code_q;
    assign rx_busy  = state_q != S_IDLE;
    assign cnt_ok   = cnt_ok_q;
    assign cnt_err  = cnt_err_q;
endmodule

// File: tb/tb_commu_rx_main.sv
// tb_commu_rx_main: directed and randomized frames checked every cycle against a
// queue-based frame model, plus hand-computed literal expectations.
module tb_commu_rx_main;
    localparam int         MAXL = 64;
    localparam int         TO   = 100;
    localparam logic [7:0] H0   = 8'hEB;
    localparam logic [7:0] H1   = 8'h90;
    localparam logic [7:0] TL   = 8'h0D;

    typedef logic [7:0] bq_t[$];

    logic        clk_sys = 1'b0;
    logic        rst     = 1'b1;
    logic        rx_vld  = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [7:0]  cfg     = 8'h01;
    logic        out_rdy = 1'b1;
    logic        out_vld, out_last, frm_ok, frm_err, rx_busy;
    logic [7:0]  out_data;
    logic [2:0]  err_code;
    logic [15:0] cnt_ok, cnt_err;

    commu_rx_main #(.MAX_LEN(MAXL), .TIMEOUT(TO)) dut (
        .clk_sys(clk_sys), .rst(rst), .rx_vld(rx_vld), .rx_data(rx_data), .cfg_recvEn(cfg),
        .out_vld(out_vld), .out_data(out_data), .out_last(out_last), .out_rdy(out_rdy),
        .frm_ok(frm_ok), .frm_err(frm_err), .err_code(err_code), .rx_busy(rx_busy),
        .cnt_ok(cnt_ok), .cnt_err(cnt_err)
    );

    always #5 clk_sys = ~clk_sys;

    int         checks = 0;
    int         fails  = 0;
    bit         armed  = 0;
    bit         rand_rdy = 0;
    bq_t        fr;
    bq_t        drain;
    int         gap, m_cok, m_cerr, n, len;
    bit         m_ok, m_err, ok_n, err_n;
    logic [2:0] m_code, c_n;
    logic [7:0] s;
    logic [8:0] got[$];
    logic [2:0] errs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: fr holds the bytes of the frame being hunted, drain the payload awaiting output
    always @(posedge clk_sys) begin
        if (rst) begin
            fr.delete();
            drain.delete();
            gap = 0; m_ok = 0; m_err = 0; m_code = 0; m_cok = 0; m_cerr = 0;
            armed = 1;
        end else begin
            ok_n = 0; err_n = 0; c_n = m_code;
            if (m_ok && m_cok < 65535) m_cok++;
            if (m_err && m_cerr < 65535) m_cerr++;
            if (drain.size() > 0) begin
                if (rx_vld) begin err_n = 1; c_n = 5; end
                if (out_rdy) void'(drain.pop_front());
            end else if (fr.size() > 0) begin
                if (!cfg[0]) begin
                    fr.delete(); gap = 0;
                end else if (rx_vld) begin
                    gap = 0;
                    fr.push_back(rx_data);
                    n = fr.size();
                    if (n == 2) begin
                        if (rx_data != H1) begin
                            fr.delete();
                            if (rx_data == H0) fr.push_back(rx_data);
                        end
                    end else if (n == 3) begin
                        if (rx_data == 0 || int'(rx_data) > MAXL) begin
                            err_n = 1; c_n = 1; fr.delete();
                        end
                    end else begin
                        len = int'(fr[2]);
                        if (n == len + 4) begin
                            s = 0;
                            for (int i = 2; i < n - 1; i++) s += fr[i];
                            if (s != rx_data) begin err_n = 1; c_n = 2; fr.delete(); end
                        end else if (n == len + 5) begin
                            if (rx_data != TL) begin
                                err_n = 1; c_n = 3;
                            end else begin
                                for (int i = 3; i < 3 + len; i++) drain.push_back(fr[i]);
                                ok_n = 1;
                            end
                            fr.delete();
                        end
                    end
                end else begin
                    gap++;
                    if (gap == TO) begin err_n = 1; c_n = 4; fr.delete(); gap = 0; end
                end
            end else if (rx_vld && cfg[0] && rx_data == H0) begin
                fr.push_back(rx_data); gap = 0;
            end
            m_ok = ok_n; m_err = err_n; m_code = c_n;
        end
    end

    always @(negedge clk_sys) if (armed) begin
        chk("out_vld", out_vld, drain.size() > 0);
        if (drain.size() > 0) begin
            chk("out_data", out_data, drain[0]);
            chk("out_last", out_last, drain.size() == 1);
        end
        chk("frm_ok", frm_ok, m_ok);
        chk("frm_err", frm_err, m_err);
        chk("err_code", err_code, m_code);
        chk("rx_busy", rx_busy, fr.size() > 0 || drain.size() > 0);
        chk("cnt_ok", cnt_ok, m_cok);
        chk("cnt_err", cnt_err, m_cerr);
        if (out_vld && out_rdy) got.push_back({out_last, out_data});
        if (frm_err) errs.push_back(err_code);
    end

    task automatic tick(input int k = 1);
        repeat (k) begin
            @(posedge clk_sys);
            #1;
            if (rand_rdy) out_rdy = $urandom_range(0, 3) != 0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_vld = 1; rx_data = b;
        tick();
        rx_vld = 0;
    endtask

    task automatic send_q(input bq_t q, input bit gaps, input int drop_at);
        foreach (q[i]) begin
            if (i == drop_at) begin cfg = 8'h00; tick(); cfg = 8'h01; end
            send(q[i]);
            if (gaps && $urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        while (rx_busy && w < 2000) begin tick(); w++; end
        chk("idle_wait", rx_busy, 0);
        tick(2);
    endtask

    function automatic bq_t frame(input bq_t p);
        bq_t q;
        logic [7:0] sm;
        sm = 8'(p.size());
        q = {H0, H1, sm};
        foreach (p[i]) begin q.push_back(p[i]); sm += p[i]; end
        q.push_back(sm);
        q.push_back(TL);
        return q;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t q, p;
        int kind, drop;
        tick(3);
        rst = 0;
        tick();
        // good frame: LEN 03, sum 03+11+22+33 = 69
        got.delete(); errs.delete();
        q = {8'hEB, 8'h90, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69, 8'h0D};
        send_q(q, 0, -1);
        wait_idle();
        chk("t1_beats", got.size(), 3);
        chk("t1_b0", got[0], 9'h011);
        chk("t1_b1", got[1], 9'h022);
        chk("t1_b2", got[2], 9'h133);
        chk("t1_cnt_ok", cnt_ok, 1);
        // bad checksum
        got.delete(); errs.delete();
        q = {8'hEB, 8'h90, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68, 8'h0D};
        send_q(q, 0, -1);
        wait_idle();
        chk("t2_errs", errs.size(), 1);
        chk("t2_code", errs[0], 2);
        chk("t2_no_out", got.size(), 0);
        chk("t2_cnt_err", cnt_err, 1);
        // bad LEN 0 and 65, then a frame behind a repeated HEAD0
        got.delete(); errs.delete();
        q = {8'hEB, 8'h90, 8'h00, 8'hEB, 8'h90, 8'h41, 8'hEB, 8'hEB, 8'h90, 8'h02, 8'h05, 8'h06, 8'h0D, 8'h0D};
        send_q(q, 0, -1);
        wait_idle();
        chk("t3_errs", errs.size(), 2);
        chk("t3_code0", errs[0], 1);
        chk("t3_code1", errs[1], 1);
        chk("t3_beats", got.size(), 2);
        chk("t3_b1", got[1], 9'h106);
        chk("t3_cnt_ok", cnt_ok, 2);
        // maximum length frame
        got.delete();
        p.delete();
        for (int i = 0; i < MAXL; i++) p.push_back(8'($urandom));
        send_q(frame(p), 0, -1);
        wait_idle();
        chk("tmax_beats", got.size(), MAXL);
        chk("tmax_last", got[MAXL-1], {1'b1, p[MAXL-1]});
        // timeout exactly after TO idle cycles
        errs.delete();
        q = {8'hEB, 8'h90, 8'h02, 8'hAA};
        send_q(q, 0, -1);
        tick(TO - 1);
        chk("t4_early", frm_err, 0);
        tick();
        chk("t4_err", frm_err, 1);
        chk("t4_code", err_code, 4);
        got.delete();
        q = {8'hEB, 8'h90, 8'h01, 8'h7F, 8'h80, 8'h0D};
        send_q(q, 0, -1);
        wait_idle();
        chk("t4_next", got.size() == 1 ? got[0] : 9'h000, 9'h17F);
        // overrun while held: sum 04+A1+B2+C3+D4 = EE
        got.delete(); errs.delete();
        out_rdy = 0;
        q = {8'hEB, 8'h90, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hEE, 8'h0D};
        send_q(q, 0, -1);
        tick(5);
        send(8'h55);
        tick(4);
        chk("t5_errs", errs.size(), 1);
        chk("t5_code", errs[0], 5);
        chk("t5_hold", out_data, 8'hA1);
        out_rdy = 1;
        wait_idle();
        chk("t5_beats", got.size(), 4);
        chk("t5_b2", got[2], 9'h0C3);
        chk("t5_b3", got[3], 9'h1D4);
        // bad tail, then enable dropped mid-payload
        errs.delete();
        q = {8'hEB, 8'h90, 8'h01, 8'h33, 8'h34, 8'h0A};
        send_q(q, 0, -1);
        tick(2);
        chk("t6_code", errs.size() == 1 ? errs[0] : 3'd0, 3);
        errs.delete();
        q = {8'hEB, 8'h90, 8'h04, 8'h01, 8'h02};
        send_q(q, 0, -1);
        cfg = 8'h00;
        tick();
        cfg = 8'h01;
        tick(2);
        chk("t6_idle", rx_busy, 0);
        chk("t6_noerr", errs.size(), 0);
        // reset while output is pending
        out_rdy = 0;
        q = {8'h5A, 8'hA5};
        send_q(frame(q), 0, -1);
        tick(2);
        chk("t7_vld", out_vld, 1);
        rst = 1;
        tick();
        rst = 0;
        chk("t7_rst_vld", out_vld, 0);
        chk("t7_rst_cnt", cnt_ok, 0);
        out_rdy = 1;
        tick(2);
        // randomized frames with random back-pressure
        rand_rdy = 1;
        repeat (60) begin
            kind = $urandom_range(0, 9);
            p.delete();
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(1, MAXL) : $urandom_range(1, 6);
            for (int i = 0; i < len; i++) p.push_back(8'($urandom));
            q = frame(p);
            drop = -1;
            case (kind)
                0: q[2] = $urandom_range(0, 1) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255));
                1: q[q.size()-2] = q[q.size()-2] ^ 8'h01;
                2: q[q.size()-1] = 8'h0A;
                3: q.push_front($urandom_range(0, 1) ? H0 : 8'($urandom));
                4: drop = $urandom_range(1, q.size() - 1);
                default: ;
            endcase
            send_q(q, 1, drop);
            if ($urandom_range(0, 4) != 0) wait_idle();
        end
        rand_rdy = 0;
        out_rdy = 1;
        wait_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
